// File: rtl/reg_file16.sv
// Register file: 2**ADDR_W words x WIDTH bits, one synchronous write port, two read ports.
// Latency: reads are combinational (READ_REG=0) or registered with one cycle (READ_REG=1).
// Backpressure: none; a write is accepted on every rising edge where Write=1 and Reset_n=1.
module reg_file16 #(
  parameter int          WIDTH     = 16,
  parameter int          ADDR_W    = 4,
  parameter int          ZERO_REG  = 1,
  parameter int          BYPASS    = 1,
  parameter int          READ_REG  = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Write,
  input  logic [ADDR_W-1:0] WAddr,
  input  logic [WIDTH-1:0]  I,
  input  logic [ADDR_W-1:0] RAddrA,
  input  logic [ADDR_W-1:0] RAddrB,
  output logic [WIDTH-1:0]  OA,
  output logic [WIDTH-1:0]  OB
);

  localparam int             DEPTH = 2 ** ADDR_W;
  localparam bit             ZERO  = (ZERO_REG != 0);
  localparam bit             BYP   = (BYPASS != 0);
  // Reset value is truncated to the data width.
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_en;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // A write to the hardwired zero entry is dropped here, so entry 0 never leaves 0.
  assign wr_en = Write && !(ZERO && (WAddr == '0));

  // Next-state of the storage array: hold everything, update only the addressed entry.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[WAddr] = I;
    end
  end

  // Storage array; reset wins over a concurrent write.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (ZERO && (i == 0)) ? '0 : RST_V;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read data with optional write forwarding; the zero entry overrides everything.
  // Forwarding is gated by Reset_n because the write does not land during reset.
  always_comb begin
    rd_a = mem_q[RAddrA];
    rd_b = mem_q[RAddrB];
    if (BYP && wr_en && Reset_n && (RAddrA == WAddr)) begin
      rd_a = I;
    end
    if (BYP && wr_en && Reset_n && (RAddrB == WAddr)) begin
      rd_b = I;
    end
    if (ZERO && (RAddrA == '0)) begin
      rd_a = '0;
    end
    if (ZERO && (RAddrB == '0)) begin
      rd_b = '0;
    end
  end

  if (READ_REG != 0) begin : g_rreg
    logic [WIDTH-1:0] oa_q, ob_q, oa_d, ob_d;

    // Capture the read result of the address presented at this edge.
    always_comb begin
      oa_d = rd_a;
      ob_d = rd_b;
    end

    // Output registers clear on reset.
    always_ff @(posedge CLK) begin
      if (!Reset_n) begin
        oa_q <= '0;
        ob_q <= '0;
      end else begin
        oa_q <= oa_d;
        ob_q <= ob_d;
      end
    end

    assign OA = oa_q;
    assign OB = ob_q;
  end else begin : g_rcomb
    assign OA = rd_a;
    assign OB = rd_b;
  end

endmodule

// File: tb/tb_reg_file16.sv
// Directed bench for reg_file16: four instances cover READ_REG x BYPASS with shared stimulus.
// Combinational instances are sampled mid-cycle; registered ones 1 time unit after the edge.
// A 16-entry mirror array provides expected contents; bypass expectations are hand-derived.
module tb_reg_file16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr;
  logic [3:0]  waddr;
  logic [15:0] wdat;
  logic [3:0]  raddr_a;
  logic [3:0]  raddr_b;
  logic [15:0] oa_00, ob_00, oa_01, ob_01, oa_10, ob_10, oa_11, ob_11;

  logic [15:0] model [16];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  // Naming: oa_<READ_REG><BYPASS>
  reg_file16 #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0), .READ_REG(0), .RESET_VAL(16'h00A5))
    u_r0b0 (.CLK(clk), .Reset_n(rst_n), .Write(wr), .WAddr(waddr), .I(wdat),
            .RAddrA(raddr_a), .RAddrB(raddr_b), .OA(oa_00), .OB(ob_00));
  reg_file16 #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1), .READ_REG(0), .RESET_VAL(16'h00A5))
    u_r0b1 (.CLK(clk), .Reset_n(rst_n), .Write(wr), .WAddr(waddr), .I(wdat),
            .RAddrA(raddr_a), .RAddrB(raddr_b), .OA(oa_01), .OB(ob_01));
  reg_file16 #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0), .READ_REG(1), .RESET_VAL(16'h00A5))
    u_r1b0 (.CLK(clk), .Reset_n(rst_n), .Write(wr), .WAddr(waddr), .I(wdat),
            .RAddrA(raddr_a), .RAddrB(raddr_b), .OA(oa_10), .OB(ob_10));
  reg_file16 #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1), .READ_REG(1), .RESET_VAL(16'h00A5))
    u_r1b1 (.CLK(clk), .Reset_n(rst_n), .Write(wr), .WAddr(waddr), .I(wdat),
            .RAddrA(raddr_a), .RAddrB(raddr_b), .OA(oa_11), .OB(ob_11));

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_rd(input logic [3:0] a, input bit byp, input bit w,
                                         input logic [3:0] wa, input logic [15:0] d);
    if (a == 4'd0) return 16'h0000;
    if (byp && w && (a == wa)) return d;
    return model[a];
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 16; i++) model[i] = (i == 0) ? 16'h0000 : 16'h00A5;
  endtask

  // One cycle with Write=0; I is driven with arbitrary data that must be ignored.
  task automatic read_cycle(input logic [3:0] ra, input logic [3:0] rb, input logic [15:0] junk);
    @(negedge clk);
    wr = 1'b0; waddr = ra ^ rb; wdat = junk; raddr_a = ra; raddr_b = rb;
    #2;
    check_eq($sformatf("rd r0b0 A a%0d", ra), oa_00, model[ra]);
    check_eq($sformatf("rd r0b0 B a%0d", rb), ob_00, model[rb]);
    check_eq($sformatf("rd r0b1 A a%0d", ra), oa_01, model[ra]);
    check_eq($sformatf("rd r0b1 B a%0d", rb), ob_01, model[rb]);
    @(posedge clk); #1;
    check_eq($sformatf("rd r1b0 A a%0d", ra), oa_10, model[ra]);
    check_eq($sformatf("rd r1b0 B a%0d", rb), ob_10, model[rb]);
    check_eq($sformatf("rd r1b1 A a%0d", ra), oa_11, model[ra]);
    check_eq($sformatf("rd r1b1 B a%0d", rb), ob_11, model[rb]);
  endtask

  // One write cycle with simultaneous reads; expectations use pre-write model contents.
  task automatic write_cycle(input logic [3:0] wa, input logic [15:0] d,
                             input logic [3:0] ra, input logic [3:0] rb);
    @(negedge clk);
    wr = 1'b1; waddr = wa; wdat = d; raddr_a = ra; raddr_b = rb;
    #2;
    check_eq($sformatf("wr r0b0 A w%0d r%0d", wa, ra), oa_00, exp_rd(ra, 0, 1, wa, d));
    check_eq($sformatf("wr r0b0 B w%0d r%0d", wa, rb), ob_00, exp_rd(rb, 0, 1, wa, d));
    check_eq($sformatf("wr r0b1 A w%0d r%0d", wa, ra), oa_01, exp_rd(ra, 1, 1, wa, d));
    check_eq($sformatf("wr r0b1 B w%0d r%0d", wa, rb), ob_01, exp_rd(rb, 1, 1, wa, d));
    @(posedge clk); #1;
    check_eq($sformatf("wr r1b0 A w%0d r%0d", wa, ra), oa_10, exp_rd(ra, 0, 1, wa, d));
    check_eq($sformatf("wr r1b0 B w%0d r%0d", wa, rb), ob_10, exp_rd(rb, 0, 1, wa, d));
    check_eq($sformatf("wr r1b1 A w%0d r%0d", wa, ra), oa_11, exp_rd(ra, 1, 1, wa, d));
    check_eq($sformatf("wr r1b1 B w%0d r%0d", wa, rb), ob_11, exp_rd(rb, 1, 1, wa, d));
    if (wa != 4'd0) model[wa] = d;
  endtask

  // Reset edge with a concurrent write that must be discarded.
  task automatic reset_cycle(input logic [3:0] wa, input logic [15:0] d);
    @(negedge clk);
    rst_n = 1'b0; wr = 1'b1; waddr = wa; wdat = d; raddr_a = wa; raddr_b = 4'd1;
    @(posedge clk); #1;
    check_eq("rst r1b0 A", oa_10, 16'h0000);
    check_eq("rst r1b0 B", ob_10, 16'h0000);
    check_eq("rst r1b1 A", oa_11, 16'h0000);
    check_eq("rst r1b1 B", ob_11, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1; wr = 1'b0;
    reset_model();
  endtask

  initial begin
    rst_n = 1'b1; wr = 1'b0; waddr = '0; wdat = '0; raddr_a = '0; raddr_b = '0;

    // 1. Reset (with a write attempt), then every address reads 00A5 except addr 0.
    reset_cycle(4'd3, 16'hFFFF);
    for (int a = 0; a < 16; a++) read_cycle(4'(a), 4'(15 - a), 16'h5A5A);

    // 2. Two writes, then read both back on separate ports.
    write_cycle(4'd3, 16'h1234, 4'd1, 4'd2);
    write_cycle(4'd15, 16'hBEEF, 4'd3, 4'd14);
    read_cycle(4'd3, 4'd15, 16'h0000);

    // 3. Write to the zero entry, including a same-cycle read of it.
    write_cycle(4'd0, 16'hFFFF, 4'd0, 4'd0);
    read_cycle(4'd0, 4'd0, 16'hFFFF);

    // 4. Read-during-write on addr 5: bypass vs. old data, then new data next cycle.
    write_cycle(4'd5, 16'h0001, 4'd6, 4'd7);
    write_cycle(4'd5, 16'h0002, 4'd5, 4'd5);
    read_cycle(4'd5, 4'd5, 16'h0000);
    // Ports on different addresses while one of them matches the write.
    write_cycle(4'd9, 16'h8001, 4'd5, 4'd9);

    // 5. Write=0 with I toggling: nothing may change.
    for (int i = 0; i < 8; i++)
      read_cycle(4'(2 * i), 4'(2 * i + 1), (i % 2 == 0) ? 16'hFFFF : 16'h0000);

    // 6. Fill every entry, then reset with a concurrent write.
    for (int a = 0; a < 16; a++)
      write_cycle(4'(a), 16'h1000 + 16'(a) * 16'h0111, 4'(a), 4'(15 - a));
    for (int a = 0; a < 16; a += 5) read_cycle(4'(a), 4'(a + 1), 16'h0F0F);
    reset_cycle(4'd7, 16'hDEAD);
    for (int a = 0; a < 16; a++) read_cycle(4'(a), 4'(a), 16'hC3C3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
